// File: rtl/matrix_bank_ram.sv
// rtl/matrix_bank_ram.sv - banked simple-dual-port RAM with per-bank write mask and clear engine
module matrix_bank_ram #(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_BANKS  = 4,
    parameter int DEPTH      = 64,
    parameter int OUT_REG    = 0,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int ROW_W     = NUM_BANKS * WORD_WIDTH
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [NUM_BANKS-1:0] wr_bank_mask,
    input  logic [ROW_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ROW_W-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // One extra bit so the range check stays meaningful when DEPTH is a power of two
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    logic [1:0]            state;
    logic [ADDR_W-1:0]     clr_cnt;
    logic [WORD_WIDTH-1:0] mem [NUM_BANKS][DEPTH];
    logic                  idle;
    logic                  wr_ok;
    logic                  rd_acc;
    logic                  rd_in_range;
    logic                  clr_we;
    logic [ROW_W-1:0]      s1_data;
    logic                  s1_valid;

    // A clear request in IDLE wins over any same-cycle read or write
    assign idle        = (state == ST_IDLE);
    assign wr_ok       = idle && !clr_req && wr_en && ({1'b0, wr_addr} < DEPTH_C);
    assign rd_acc      = idle && !clr_req && rd_en;
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
    assign clr_we      = (state == ST_CLEAR);
    assign clr_busy    = !idle;
    assign clr_done    = (state == ST_DONE);

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == LAST_C) begin
                        state   <= ST_DONE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage has no reset so it maps onto block RAM
    always_ff @(posedge clka) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (clr_we) begin
                mem[b][clr_cnt] <= '0;
            end else if (wr_ok && wr_bank_mask[b]) begin
                mem[b][wr_addr] <= wr_data[b*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    // Registered read samples the array before this edge's write lands: read-first
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_acc;
            if (rd_acc) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    s1_data[b*WORD_WIDTH +: WORD_WIDTH] <= rd_in_range ? mem[b][rd_addr] : '0;
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            always_ff @(posedge clka or posedge rsta) begin
                if (rsta) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= s1_valid;
                    if (s1_valid) begin
                        rd_data <= s1_data;
                    end
                end
            end
        end else begin : g_no_out_reg
            assign rd_data  = s1_data;
            assign rd_valid = s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_matrix_bank_ram.sv
// tb/tb_matrix_bank_ram.sv - scoreboard bench for matrix_bank_ram, two configurations on shared stimulus
module tb_matrix_bank_ram;
    localparam int W  = 16;
    localparam int NB = 4;
    localparam int RW = W * NB;
    localparam int AW = 6;
    localparam int D0 = 64;
    localparam int D1 = 48;

    logic clk = 1'b0;
    logic rst;
    logic wr_en, rd_en, clr_req;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [NB-1:0] wr_bank_mask;
    logic [RW-1:0] wr_data;
    logic [RW-1:0] rd_data0, rd_data1;
    logic rd_valid0, rd_valid1, clr_busy0, clr_busy1, clr_done0, clr_done1;

    int total = 0;
    int bad   = 0;

    logic [RW-1:0] m0 [D0];
    logic [RW-1:0] m1 [D1];
    logic [RW-1:0] q0 [$];
    logic [RW-1:0] q1 [$];

    always #5 clk = ~clk;

    matrix_bank_ram #(.WORD_WIDTH(W), .NUM_BANKS(NB), .DEPTH(D0), .OUT_REG(0)) dut0 (
        .clka(clk), .rsta(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_bank_mask(wr_bank_mask),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .clr_req(clr_req), .clr_busy(clr_busy0), .clr_done(clr_done0)
    );

    matrix_bank_ram #(.WORD_WIDTH(W), .NUM_BANKS(NB), .DEPTH(D1), .OUT_REG(1)) dut1 (
        .clka(clk), .rsta(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_bank_mask(wr_bank_mask),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .clr_req(clr_req), .clr_busy(clr_busy1), .clr_done(clr_done1)
    );

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every presented read result is matched against the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid0) begin
                total++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL dut0_unexpected_valid actual=%h required=no_result", rd_data0);
                end else begin
                    logic [RW-1:0] e;
                    e = q0.pop_front();
                    if (rd_data0 !== e) begin
                        bad++;
                        $display("FAIL dut0_rd_data actual=%h required=%h", rd_data0, e);
                    end
                end
            end
            if (rd_valid1) begin
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL dut1_unexpected_valid actual=%h required=no_result", rd_data1);
                end else begin
                    logic [RW-1:0] e;
                    e = q1.pop_front();
                    if (rd_data1 !== e) begin
                        bad++;
                        $display("FAIL dut1_rd_data actual=%h required=%h", rd_data1, e);
                    end
                end
            end
        end
    end

    task automatic set_idle();
        wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_bank_mask = '0; wr_data = '0;
    endtask

    // One clock with the given request; the reference model is updated read-before-write
    task automatic cycle(input bit we, input logic [AW-1:0] wa, input logic [NB-1:0] mk,
                         input logic [RW-1:0] wd, input bit re, input logic [AW-1:0] ra);
        wr_en = we; wr_addr = wa; wr_bank_mask = mk; wr_data = wd;
        rd_en = re; rd_addr = ra; clr_req = 1'b0;
        if (re) begin
            q0.push_back(m0[ra]);
            if (int'(ra) < D1) q1.push_back(m1[ra]);
            else q1.push_back('0);
        end
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (mk[b]) begin
                    m0[wa][b*W +: W] = wd[b*W +: W];
                    if (int'(wa) < D1) m1[wa][b*W +: W] = wd[b*W +: W];
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        set_idle();
        @(posedge clk); #1;
    endtask

    task automatic fill_all();
        for (int a = 0; a < D0; a++) cycle(1, AW'(a), '1, {$urandom, $urandom}, 0, '0);
        set_idle();
    endtask

    task automatic read_all();
        for (int a = 0; a < D0; a++) cycle(0, '0, '0, '0, 1, AW'(a));
        repeat (3) idle_cycle();
    endtask

    // Full clear; junk requests while both engines are busy must be ignored
    task automatic run_clear(input bit junk);
        int busy0 = 0, busy1 = 0, dn0 = 0, dn1 = 0, at0 = -1, at1 = -1;
        set_idle();
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (clr_busy0) busy0++;
            if (clr_busy1) busy1++;
            if (clr_done0) begin dn0++; at0 = i; end
            if (clr_done1) begin dn1++; at1 = i; end
            if (junk && i < 40) begin
                wr_en = 1'b1; wr_addr = AW'($urandom); wr_bank_mask = '1;
                wr_data = {$urandom, $urandom}; rd_en = 1'b1; rd_addr = AW'($urandom);
            end else begin
                set_idle();
            end
            @(posedge clk); #1;
        end
        set_idle();
        check("clr_busy_cycles0", RW'(busy0), RW'(D0 + 1));
        check("clr_busy_cycles1", RW'(busy1), RW'(D1 + 1));
        check("clr_done_count0", RW'(dn0), RW'(1));
        check("clr_done_count1", RW'(dn1), RW'(1));
        check("clr_done_pos0", RW'(at0), RW'(D0));
        check("clr_done_pos1", RW'(at1), RW'(D1));
        for (int a = 0; a < D0; a++) m0[a] = '0;
        for (int a = 0; a < D1; a++) m1[a] = '0;
    endtask

    initial begin
        logic [6:0] v0, v1;
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_data0", rd_data0, '0);
        check("rst_rd_data1", rd_data1, '0);
        check("rst_flags", RW'({rd_valid0, rd_valid1, clr_busy0, clr_busy1, clr_done0, clr_done1}), '0);
        rst = 1'b0;
        idle_cycle();

        run_clear(0);

        // Unwritten (cleared) row reads back zero, then latency and hold on back-to-back reads
        cycle(0, '0, '0, '0, 1, AW'(5));
        check("read5_latency_data", rd_data0, '0);
        check("read5_latency_valid", RW'(rd_valid0), RW'(1));
        idle_cycle();
        idle_cycle();
        for (int a = 0; a < 4; a++) cycle(1, AW'(a), '1, {$urandom, $urandom}, 0, '0);
        for (int j = 0; j < 7; j++) begin
            if (j < 4) cycle(0, '0, '0, '0, 1, AW'(j));
            else idle_cycle();
            v0[j] = rd_valid0;
            v1[j] = rd_valid1;
        end
        check("valid_pattern_outreg0", RW'(v0), RW'(7'b0001111));
        check("valid_pattern_outreg1", RW'(v1), RW'(7'b0011110));
        check("hold_data0", rd_data0, m0[3]);
        check("hold_data1", rd_data1, m1[3]);

        // Masked write
        cycle(1, AW'(3), 4'b1111, 64'h4444_3333_2222_1111, 0, '0);
        cycle(1, AW'(3), 4'b0101, 64'hAAAA_BBBB_CCCC_DDDD, 0, '0);
        cycle(0, '0, '0, '0, 1, AW'(3));
        check("masked_write_row", rd_data0, 64'h4444_BBBB_2222_DDDD);
        idle_cycle();

        // Read-during-write returns old contents
        cycle(1, AW'(7), '1, 64'h1, 0, '0);
        cycle(1, AW'(7), '1, 64'h2, 1, AW'(7));
        check("rdw_old_data", rd_data0, 64'h1);
        cycle(0, '0, '0, '0, 1, AW'(7));
        check("rdw_new_data", rd_data0, 64'h2);
        repeat (3) idle_cycle();

        // Random traffic; dut1 sees addresses beyond its depth
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 1), AW'($urandom), NB'($urandom), {$urandom, $urandom},
                  $urandom_range(0, 1), AW'($urandom));
        end
        repeat (3) idle_cycle();

        fill_all();
        run_clear(1);
        read_all();

        // Reset in the middle of a clear: rows 0..19 zeroed, rest keep their data
        fill_all();
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("abort_rd_data0", rd_data0, '0);
        check("abort_flags", RW'({rd_valid0, rd_valid1, clr_busy0, clr_busy1, clr_done0, clr_done1}), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int a = 0; a < 20; a++) begin
            m0[a] = '0;
            m1[a] = '0;
        end
        read_all();
        check("scoreboard_drained0", RW'(q0.size()), '0);
        check("scoreboard_drained1", RW'(q1.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
